// File: rtl/pid_pkg.sv
// Shared PID definitions: widths, FSM state type and saturation helpers.
package pid_pkg;

  localparam int unsigned E_W    = 6;
  localparam int unsigned K_W    = 6;
  localparam int unsigned ACC_W  = 10;
  localparam int unsigned OUT_W  = 6;
  localparam int unsigned SHIFT  = 2;
  localparam int unsigned PROD_W = ACC_W + K_W;
  localparam int unsigned CNT_W  = $clog2(K_W);

  localparam logic signed [OUT_W-1:0]  OUT_MAX   = OUT_W'(2**(OUT_W-1) - 1);
  localparam logic signed [OUT_W-1:0]  OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic signed [PROD_W-1:0] OUT_MAX_P = PROD_W'(2**(OUT_W-1) - 1);
  localparam logic signed [PROD_W-1:0] OUT_MIN_P = -PROD_W'(2**(OUT_W-1));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturating add of a sign-extended error sample into the accumulator.
  function automatic logic signed [ACC_W-1:0] sat_add_acc(
    input logic signed [ACC_W-1:0] a,
    input logic signed [E_W-1:0]   b
  );
    logic signed [ACC_W:0] sum;
    sum = (ACC_W+1)'(a) + (ACC_W+1)'(b);
    if (sum[ACC_W] != sum[ACC_W-1]) begin
      return sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
    return sum[ACC_W-1:0];
  endfunction

  // Scale the product by the fixed-point shift and clamp to the output width.
  function automatic logic signed [OUT_W-1:0] sat_to_out(
    input logic signed [PROD_W-1:0] x
  );
    logic signed [PROD_W-1:0] sh;
    sh = x >>> SHIFT;
    if (sh > OUT_MAX_P) return OUT_MAX;
    if (sh < OUT_MIN_P) return OUT_MIN;
    return OUT_W'(sh);
  endfunction

endpackage

// File: rtl/serial_mult.sv
// Serial shift-add multiplier: signed a times unsigned b, one bit of b per cycle, LSB first.
// done is combinational and marks the cycle in which the final step is taken.
module serial_mult
  import pid_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic signed [ACC_W-1:0]  a,
  input  logic        [K_W-1:0]    b,
  output logic signed [PROD_W-1:0] prod,
  output logic                     done
);

  logic signed [PROD_W-1:0] a_sh;
  logic        [K_W-1:0]    b_sh;
  logic        [CNT_W-1:0]  cnt;
  logic                     run;

  assign done = run && (cnt == CNT_W'(K_W - 1));

  // Latch operands on start, then add the shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      prod <= '0;
    end else if (start) begin
      a_sh <= PROD_W'(a);
      b_sh <= b;
      cnt  <= '0;
      run  <= 1'b1;
      prod <= '0;
    end else if (run) begin
      if (b_sh[0]) prod <= prod + a_sh;
      a_sh <= a_sh <<< 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + CNT_W'(1);
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/integrator.sv
// PID integral term: saturating error accumulator scaled by K_i through a serial multiplier.
// Optional build macro INTEGRATOR_ANTIWINDUP_EN stops accumulation while the output is
// pinned at a rail and the error would push it further into that rail.
module integrator
  import pid_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic signed [E_W-1:0]   e,
  input  logic        [K_W-1:0]   K_i,
  output logic signed [OUT_W-1:0] i_contrib,
  output logic                    i_valid,
  output logic                    busy
);

  state_t                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc, acc_d;
  logic                     pending, pending_d;
  logic signed [OUT_W-1:0]  contrib_d;
  logic                     valid_d;
  logic                     start_c;
  logic                     skip_c;
  logic signed [PROD_W-1:0] prod;
  logic                     mult_done;

  // Anti-windup gate: hold the accumulator when the output rail and error sign agree.
`ifdef INTEGRATOR_ANTIWINDUP_EN
  always_comb begin
    skip_c = 1'b0;
    if ((i_contrib == OUT_MAX) && !e[E_W-1] && (e != '0)) skip_c = 1'b1;
    if ((i_contrib == OUT_MIN) && e[E_W-1])               skip_c = 1'b1;
  end
`else
  assign skip_c = 1'b0;
`endif

  // Next accumulator value; also the operand latched when a multiply starts.
  always_comb begin
    acc_d = acc;
    if (ena && !skip_c) acc_d = sat_add_acc(acc, e);
  end

  serial_mult u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start_c),
    .a     (acc_d),
    .b     (K_i),
    .prod  (prod),
    .done  (mult_done)
  );

  // Next-state, pending flag and output update logic.
  always_comb begin
    state_d   = state_q;
    pending_d = pending;
    contrib_d = i_contrib;
    valid_d   = 1'b0;
    start_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ena || pending) begin
          start_c   = 1'b1;
          pending_d = 1'b0;
          state_d   = MUL;
        end
      end
      MUL: begin
        if (ena)       pending_d = 1'b1;
        if (mult_done) state_d   = DONE;
      end
      DONE: begin
        contrib_d = sat_to_out(prod);
        valid_d   = 1'b1;
        pending_d = ena;
        if (pending) begin
          start_c = 1'b1;
          state_d = MUL;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc       <= '0;
      pending   <= 1'b0;
      i_contrib <= '0;
      i_valid   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc       <= acc_d;
      pending   <= pending_d;
      i_contrib <= contrib_d;
      i_valid   <= valid_d;
      busy      <= (state_d != IDLE);
    end
  end

endmodule
